// File: rtl/accumulator_alu_serial.sv
// Digit-serial accumulator/ALU: one command per handshake, DIGIT bits per cycle, LSB slice first.
// Accumulator and flags commit together on the last slice; optional unsigned saturation for ADD/ADC/SUB/SBB.
module accumulator_alu_serial #(
  parameter int WIDTH    = 8,
  parameter int DIGIT    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  input  logic             bus_oe,
  output logic [WIDTH-1:0] bus_out,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int IDX_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADC  = 4'd3;
  localparam logic [3:0] OP_SBB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             flag_c_reg, flag_z_reg, flag_n_reg, flag_v_reg;
  logic             done_reg;

  logic [DIGIT-1:0] a_slice, b_slice, slice_res;
  logic [DIGIT:0]   sum_ext, diff_ext;
  logic             slice_cout;
  logic             last_slice;
  logic [DIGIT-1:0] res_slice [NSTEP];
  logic [WIDTH-1:0] result_full;

  logic [WIDTH-1:0] acc_next;
  logic             flag_c_next, flag_z_next, flag_n_next, flag_v_next;
  logic [WIDTH-1:0] zn_src;
  logic             zn_update;
  logic             a_msb, b_msb, r_msb;

  assign cmd_ready  = (state_reg == IDLE);
  assign done       = done_reg;
  assign acc_out    = acc_reg;
  assign bus_out    = bus_oe ? acc_reg : '0;
  assign flag_c     = flag_c_reg;
  assign flag_z     = flag_z_reg;
  assign flag_n     = flag_n_reg;
  assign flag_v     = flag_v_reg;
  assign last_slice = (idx_reg == IDX_W'(NSTEP - 1));

  // One DIGIT-wide slice of the operation; the borrow is the sign bit of the widened difference.
  always_comb begin
    a_slice    = acc_reg[idx_reg*DIGIT +: DIGIT];
    b_slice    = b_reg[idx_reg*DIGIT +: DIGIT];
    sum_ext    = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};
    diff_ext   = {1'b0, a_slice} - {1'b0, b_slice} - {{DIGIT{1'b0}}, carry_reg};
    slice_res  = b_slice;
    slice_cout = 1'b0;
    case (op_reg)
      OP_ADD, OP_ADC: begin
        slice_res  = sum_ext[DIGIT-1:0];
        slice_cout = sum_ext[DIGIT];
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        slice_res  = diff_ext[DIGIT-1:0];
        slice_cout = diff_ext[DIGIT];
      end
      OP_AND:  slice_res = a_slice & b_slice;
      OP_OR:   slice_res = a_slice | b_slice;
      OP_XOR:  slice_res = a_slice ^ b_slice;
      default: slice_res = b_slice;
    endcase
  end

  // Full result as it will stand after the current slice lands in the shadow register.
  for (genvar gi = 0; gi < NSTEP; gi++) begin : g_slice
    assign res_slice[gi] = (idx_reg == IDX_W'(gi)) ? slice_res : shadow_reg[gi*DIGIT +: DIGIT];
  end

  always_comb begin
    result_full = '0;
    for (int i = 0; i < NSTEP; i++) begin
      result_full[i*DIGIT +: DIGIT] = res_slice[i];
    end
  end

  always_comb begin
    a_msb       = acc_reg[WIDTH-1];
    b_msb       = b_reg[WIDTH-1];
    r_msb       = result_full[WIDTH-1];
    acc_next    = acc_reg;
    flag_c_next = flag_c_reg;
    flag_v_next = flag_v_reg;
    zn_src      = result_full;
    zn_update   = 1'b1;
    case (op_reg)
      OP_LOAD: begin
        acc_next = b_reg;
        zn_src   = b_reg;
      end
      OP_ADD, OP_ADC: begin
        flag_c_next = slice_cout;
        flag_v_next = (a_msb == b_msb) && (r_msb != a_msb);
        acc_next    = ((SATURATE != 0) && slice_cout) ? '1 : result_full;
        zn_src      = acc_next;
      end
      OP_SUB, OP_SBB: begin
        flag_c_next = slice_cout;
        flag_v_next = (a_msb != b_msb) && (r_msb != a_msb);
        acc_next    = ((SATURATE != 0) && slice_cout) ? '0 : result_full;
        zn_src      = acc_next;
      end
      OP_CMP: begin
        flag_c_next = slice_cout;
        flag_v_next = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_AND, OP_OR, OP_XOR: begin
        flag_c_next = 1'b0;
        flag_v_next = 1'b0;
        acc_next    = result_full;
      end
      OP_CLR: begin
        flag_c_next = 1'b0;
        flag_v_next = 1'b0;
        acc_next    = '0;
        zn_src      = '0;
      end
      default: zn_update = 1'b0;
    endcase
    flag_z_next = zn_update ? (zn_src == '0) : flag_z_reg;
    flag_n_next = zn_update ? zn_src[WIDTH-1] : flag_n_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = BUSY;
      BUSY:    if (last_slice) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      shadow_reg <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
      flag_v_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (state_reg == IDLE) begin
        if (cmd_valid) begin
          op_reg    <= cmd_op;
          b_reg     <= cmd_data;
          idx_reg   <= '0;
          carry_reg <= ((cmd_op == OP_ADC) || (cmd_op == OP_SBB)) ? flag_c_reg : 1'b0;
        end
      end else begin
        shadow_reg[idx_reg*DIGIT +: DIGIT] <= slice_res;
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + IDX_W'(1);
        if (last_slice) begin
          acc_reg    <= acc_next;
          flag_c_reg <= flag_c_next;
          flag_z_reg <= flag_z_next;
          flag_n_reg <= flag_n_next;
          flag_v_reg <= flag_v_next;
          done_reg   <= 1'b1;
        end
      end
    end
  end

endmodule
